// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: channel indices,
// default timing constants per clock rate and a width helper.
package input_conditioner_pkg;

    // Channel assignment of the board's push-buttons.
    typedef enum logic [2:0] {
        BTN_UP     = 3'd0,
        BTN_DOWN   = 3'd1,
        BTN_LEFT   = 3'd2,
        BTN_RIGHT  = 3'd3,
        BTN_CENTER = 3'd4
    } btn_e;

    localparam int BTN_COUNT = 5;

    // Default timing at 50 MHz: 10 ms debounce, 0.5 s / 0.1 s repeat.
    localparam int DB_CYCLES_50MHZ     = 500000;
    localparam int REP_DELAY_50MHZ     = 25000000;
    localparam int REP_PERIOD_50MHZ    = 5000000;

    // Same intervals at 100 MHz.
    localparam int DB_CYCLES_100MHZ    = 1000000;
    localparam int REP_DELAY_100MHZ    = 50000000;
    localparam int REP_PERIOD_100MHZ   = 10000000;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin/strobe bundle between board pins and the game logic.
// d: raw pins; level/rise/fall/press: conditioned outputs.
interface input_conditioner_if #(
    parameter int N_CH = 5
);
    logic [N_CH-1:0] d;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] press;

    modport master (
        output d,
        input  level, rise, fall, press
    );

    modport slave (
        input  d,
        output level, rise, fall, press
    );
endinterface

// File: rtl/input_conditioner_debounce_ch.sv
// One channel: debounce of the synchronized level, edge strobes, auto-repeat.
// Ports: clk, rst (sync, active-high), s (synced pin), level/rise/fall/press.
module input_conditioner_debounce_ch
    import input_conditioner_pkg::*;
#(
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic level,
    output logic rise,
    output logic fall,
    output logic press
);
    localparam int CW = clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic          acc;

    // New level has now held for DB_CYCLES consecutive edges.
    assign acc = (s != level_q) && (cnt == CMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (s == level_q) begin
                cnt <= '0;
            end else if (acc) begin
                cnt     <= '0;
                level_q <= s;
                rise_q  <= s;
                fall_q  <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

    generate
        if (REPEAT_EN != 0) begin : g_rep
            localparam int RMAX_I = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                    REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RW = clog2(RMAX_I + 1);
            localparam logic [RW-1:0] DMAX = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] PMAX = RW'(REPEAT_PERIOD - 1);

            logic [RW-1:0] rcnt;
            logic          rep_q;
            logic          press_q;
            logic [RW-1:0] lim;

            // First tick waits the long delay, later ones the period.
            assign lim = rep_q ? PMAX : DMAX;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rcnt    <= '0;
                    rep_q   <= 1'b0;
                    press_q <= 1'b0;
                end else begin
                    press_q <= 1'b0;
                    if (acc) begin
                        rcnt    <= '0;
                        rep_q   <= 1'b0;
                        press_q <= s;
                    end else if (level_q) begin
                        if (rcnt == lim) begin
                            rcnt    <= '0;
                            rep_q   <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end else begin
                        rcnt  <= '0;
                        rep_q <= 1'b0;
                    end
                end
            end

            assign press = press_q;
        end else begin : g_norep
            assign press = rise_q;
        end
    endgenerate

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button front end: per-channel synchronizer chains feeding
// debounce/edge/repeat channels. Ports: clk, rst (sync, active-high), io.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_CH          = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 500000,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input_conditioner_if.slave  io
);
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("input_conditioner: SYNC_STAGES must be >= 2");
        end
        if (DB_CYCLES < 1) begin : g_bad_db
            $error("input_conditioner: DB_CYCLES must be >= 1");
        end
        if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
            $error("input_conditioner: REPEAT_* must be >= 1");
        end
    endgenerate

    localparam logic INV = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync_q [N_CH];
    logic [N_CH-1:0]        s;
    logic [N_CH-1:0]        level_w;
    logic [N_CH-1:0]        rise_w;
    logic [N_CH-1:0]        fall_w;
    logic [N_CH-1:0]        press_w;

    // Synchronizers carry no reset: pins go straight into the first flop.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < N_CH; ch++) begin
            sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], io.d[ch]};
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            assign s[g] = sync_q[g][SYNC_STAGES-1] ^ INV;

            input_conditioner_debounce_ch #(
                .DB_CYCLES     (DB_CYCLES),
                .REPEAT_EN     (REPEAT_EN),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_ch (
                .clk   (clk),
                .rst   (rst),
                .s     (s[g]),
                .level (level_w[g]),
                .rise  (rise_w[g]),
                .fall  (fall_w[g]),
                .press (press_w[g])
            );
        end
    endgenerate

    assign io.level = level_w;
    assign io.rise  = rise_w;
    assign io.fall  = fall_w;
    assign io.press = press_w;

endmodule
